// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the fetch path.
// Holds default widths, the fetch state encoding and the decoder done opcode.
package cpu_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  // Opcode the decoder recognises as program end.
  localparam logic [8:0] DONE_ENC = 9'b010000000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: one-cycle-latency imem, one bubble per taken branch.
// Optional RUN-cycle counter enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_unit #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               done_in,
  output logic               halted,
  output logic [15:0]        cycle_count
);

  import cpu_pkg::*;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] w_fetch_pc_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_live;
  logic            w_start_ok;

  assign w_live     = (r_state == ST_RUN);
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_pc_nxt       = r_pc;
    unique case (r_state)
      ST_IDLE, ST_HALT: begin
        if (w_start_ok) begin
          w_fetch_pc_nxt = start_addr;
          w_state_nxt    = ST_FILL;
        end
      end
      ST_FILL: begin
        w_fetch_pc_nxt = r_fetch_pc + PC_W'(1);
        w_pc_nxt       = r_fetch_pc;
        w_state_nxt    = ST_RUN;
      end
      ST_RUN: begin
        // done wins over a same-cycle branch and freezes the fetch address.
        if (done_in) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_pc_nxt = r_fetch_pc;
          if (branch_taken) begin
            w_fetch_pc_nxt = branch_target;
            w_state_nxt    = ST_FILL;
          end else begin
            w_fetch_pc_nxt = r_fetch_pc + PC_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= '0;
      r_pc       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_pc       <= w_pc_nxt;
    end
  end

  assign imem_addr   = r_fetch_pc;
  assign instr_valid = w_live;
  assign instr       = w_live ? imem_data : '0;
  assign pc          = r_pc;
  assign halted      = (r_state == ST_HALT);

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] r_cycle_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= '0;
    end else if (w_start_ok) begin
      r_cycle_count <= '0;
    end else if (w_live && (r_cycle_count != 16'hFFFF)) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected pc values are queued as programs are
// launched and popped whenever the DUT presents a live instruction.
module tb_fetch_unit;

  localparam int PW = 10;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] start_addr = '0;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_data = '0;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [PW-1:0] pc;
  logic          branch_taken = 1'b0;
  logic [PW-1:0] branch_target = '0;
  logic          done_in = 1'b0;
  logic          halted;
  logic [15:0]   cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(PW), .INSTR_W(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .done_in       (done_in),
    .halted        (halted),
    .cycle_count   (cycle_count)
  );

  function automatic logic [IW-1:0] mem_word(input int a);
    int v;
    v = a * 37 + 11;
    return v[IW-1:0];
  endfunction

  // One-cycle-latency instruction memory.
  always @(posedge clk) imem_data <= mem_word(int'(imem_addr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_start(input int a);
    start      = 1'b1;
    start_addr = a[PW-1:0];
    step();
    start      = 1'b0;
  endtask

  always @(negedge clk) begin
    int e;
    if (instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_valid", {31'd0, instr_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", {22'd0, pc}, e);
        check("sb_instr", {23'd0, instr}, {23'd0, mem_word(e)});
      end
    end else if (rst_n === 1'b1) begin
      check("instr_zero_when_idle", {23'd0, instr}, 32'd0);
    end
  end

  initial begin
    int exp_cnt;
`ifdef FETCH_CYCLE_COUNT_EN
    exp_cnt = 10;
`else
    exp_cnt = 0;
`endif

    // Reset state
    repeat (3) step();
    check("rst_imem_addr", {22'd0, imem_addr}, 32'd0);
    check("rst_pc",        {22'd0, pc},        32'd0);
    check("rst_instr",     {23'd0, instr},     32'd0);
    check("rst_valid",     {31'd0, instr_valid}, 32'd0);
    check("rst_halted",    {31'd0, halted},    32'd0);
    check("rst_cycle_cnt", {16'd0, cycle_count}, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_needs_start_valid", {31'd0, instr_valid}, 32'd0);
    check("idle_needs_start_addr",  {22'd0, imem_addr},   32'd0);

    // Straight-line run, taken branch 6 -> 20, ignored start during RUN
    exp_q.push_back(5);
    exp_q.push_back(6);
    exp_q.push_back(20);
    exp_q.push_back(21);
    exp_q.push_back(22);
    do_start(5);
    check("fill_valid_low", {31'd0, instr_valid}, 32'd0);
    step();
    check("valid_2nd_cycle", {31'd0, instr_valid}, 32'd1);
    step();
    branch_taken  = 1'b1;
    branch_target = 10'd20;
    step();
    check("branch_bubble_valid", {31'd0, instr_valid}, 32'd0);
    branch_target = 10'd99;
    step();
    branch_taken = 1'b0;
    start        = 1'b1;
    start_addr   = 10'd300;
    step();
    start = 1'b0;
    step();
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    check("t1_halted",     {31'd0, halted},    32'd1);
    check("t1_halt_addr",  {22'd0, imem_addr}, 32'd23);

    // done_in with simultaneous branch at pc=8, then restart
    exp_q.push_back(5);
    exp_q.push_back(6);
    exp_q.push_back(7);
    exp_q.push_back(8);
    exp_q.push_back(100);
    exp_q.push_back(101);
    do_start(5);
    check("restart_clears_halted", {31'd0, halted}, 32'd0);
    repeat (4) step();
    done_in       = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 10'd50;
    step();
    done_in      = 1'b0;
    branch_taken = 1'b0;
    check("done_halted",     {31'd0, halted},      32'd1);
    check("done_no_refill",  {31'd0, instr_valid}, 32'd0);
    check("done_fetch_addr", {22'd0, imem_addr},   32'd9);
    step();
    step();
    check("halt_frozen_addr", {22'd0, imem_addr}, 32'd9);
    check("halt_still",       {31'd0, halted},    32'd1);
    do_start(100);
    step();
    step();
    done_in = 1'b1;
    step();
    done_in = 1'b0;

    // Address wrap at the top of the space
    exp_q.push_back(1023);
    exp_q.push_back(0);
    exp_q.push_back(1);
    do_start(1023);
    check("wrap_fill_addr", {22'd0, imem_addr}, 32'd1023);
    step();
    check("wrap_next_addr", {22'd0, imem_addr}, 32'd0);
    step();
    step();
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    check("wrap_halted", {31'd0, halted}, 32'd1);

    // Ten RUN cycles for the optional counter
    for (int i = 0; i < 10; i++) exp_q.push_back(200 + i);
    do_start(200);
    check("cnt_clear_on_start", {16'd0, cycle_count}, 32'd0);
    for (int i = 0; i < 10; i++) step();
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    check("cnt_after_10_run", {16'd0, cycle_count}, exp_cnt);
    step();
    check("cnt_hold_in_halt", {16'd0, cycle_count}, exp_cnt);

    // Start ignored mid-RUN, then asynchronous reset mid-RUN
    exp_q.push_back(400);
    exp_q.push_back(401);
    do_start(400);
    step();
    start      = 1'b1;
    start_addr = 10'd7;
    step();
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_imem_addr", {22'd0, imem_addr},   32'd0);
    check("midrun_rst_pc",        {22'd0, pc},          32'd0);
    check("midrun_rst_instr",     {23'd0, instr},       32'd0);
    check("midrun_rst_valid",     {31'd0, instr_valid}, 32'd0);
    check("midrun_rst_halted",    {31'd0, halted},      32'd0);
    check("midrun_rst_cycle_cnt", {16'd0, cycle_count}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_idle_valid", {31'd0, instr_valid}, 32'd0);

    check("sb_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter PC_W, default 10, meaning program counter and instruction-memory address width.
REQ-002 SHALL provide parameter INSTR_W, default 9, meaning instruction width fed to the control decoder.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n as listed below.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle pulse that begins execution at start_addr.
REQ-007 start_addr  input  PC_W  first instruction address.
REQ-008 imem_addr  output  PC_W  instruction-memory read address; memory returns data exactly one cycle later.
REQ-009 imem_data  input  INSTR_W  instruction-memory read data.
REQ-010 instr  output  INSTR_W  instruction presented to the decoder.
REQ-011 instr_valid  output  1  instr is architecturally live this cycle; the decoder's write/mem/branch effects are qualified by it.
REQ-012 pc  output  PC_W  address of the instruction currently on instr.
REQ-013 branch_taken  input  1  decoder branch_en ANDed with the condition flag, for the current instr.
REQ-014 branch_target  input  PC_W  target address for a taken branch.
REQ-015 done_in  input  1  decoder done indication for the current instr.
REQ-016 halted  output  1  program finished.
REQ-017 cycle_count  output  16  count of RUN-state cycles (see Configuration).

Function
REQ-018 SHALL implement states IDLE, FILL, RUN, HALT; fetch_pc is the internal register driving imem_addr.
REQ-019 IDLE: start=1 -> fetch_pc<=start_addr, state<=FILL; start=0 -> remain.
REQ-020 FILL: instr_valid=0; fetch_pc<=fetch_pc+1, pc<=fetch_pc, state<=RUN.
REQ-021 RUN: instr_valid=1, instr=imem_data, fetch_pc<=fetch_pc+1, pc<=fetch_pc each cycle.
REQ-022 RUN with branch_taken=1: fetch_pc<=branch_target, state<=FILL, so exactly one bubble follows every taken branch (2-cycle taken-branch cost, 1 cycle otherwise).
REQ-023 RUN with done_in=1: state<=HALT, halted<=1 next cycle; done_in has priority over simultaneous branch_taken.
REQ-024 HALT: instr_valid=0, fetch_pc frozen, halted=1; start=1 -> halted<=0, fetch_pc<=start_addr, state<=FILL.
REQ-025 Whenever instr_valid=0, instr SHALL be driven to all zeros.
REQ-026 start SHALL be ignored in FILL and RUN.
REQ-027 fetch_pc increment SHALL wrap modulo 2^PC_W (max address -> 0) with no flag.
REQ-028 branch_taken and done_in SHALL be ignored when instr_valid=0.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, fetch_pc=0, imem_addr=0, pc=0, instr=0, instr_valid=0, halted=0, cycle_count=0, including mid-RUN.
REQ-030 First fetch after reset release SHALL require a start pulse.

Configuration
REQ-031 Macro FETCH_CYCLE_COUNT_EN defined: cycle_count increments by 1 per RUN cycle, saturates at 16'hFFFF, clears on start.
REQ-032 Macro undefined: cycle_count port remains, constant 0, no counter flops.

Structure
REQ-033 Package cpu_pkg SHALL hold PC_W, INSTR_W, the fetch state enum, and the 9-bit done encoding 9'b010000000.
REQ-034 No sub-module; the optional counter is an in-module conditional block.

Verification
REQ-035 Reset, start with start_addr=5, memory 5..7 non-branch -> pc sequence 5,6,7 with instr_valid=1 from 2nd cycle after start.
REQ-036 Taken branch at pc=6, target 20 -> exactly one instr_valid=0 cycle, then pc=20, 21.
REQ-037 done_in with branch_taken same cycle at pc=8 -> halted=1 next cycle, no bubble refill, fetch_pc frozen; restart via start resumes at start_addr.
REQ-038 start_addr=1023 -> pc 1023 then 0.
REQ-039 rst_n low mid-RUN -> all outputs 0 same cycle; start pulse during RUN has no effect.
REQ-040 FETCH_CYCLE_COUNT_EN defined: 10 RUN cycles -> cycle_count=10; undefined -> cycle_count=0.
